sdram_test_seq: RTL and testbench

Pattern-test sequencer sitting directly upstream of the SDRAM controller on the starter SDRAM-test board. Drives the controller's client port (req/ack, address, read/write select, write data), writes an address-derived pattern across a configurable word range, reads it back and checks every word. It reports pass count, error count and first-failure details, and trips a watchdog on a stalled controller.

---
 rtl/sdram_test_seq.sv | 196 +++++++++++++++++++
 tb/tb_sdram_test_seq.sv | 329 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/sdram_test_seq.sv
// Pattern-test sequencer for the SDRAM controller client port.
// Writes an address/pass-derived pattern, reads it back and checks each word.
module sdram_test_seq #(
    parameter int ADDR_WIDTH  = 24,
    parameter int DATA_WIDTH  = 16,
    parameter int NUM_WORDS   = 1024,
    parameter int WRITE_HOLD  = 4,
    parameter int TIMEOUT     = 1023,
    parameter int STOP_ON_ERR = 1
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  start,
    input  logic                  loop,
    output logic                  busy,
    output logic                  done,
    output logic                  timeout,
    output logic [15:0]           pass_cnt,
    output logic [15:0]           err_cnt,
    output logic [ADDR_WIDTH-1:0] first_err_addr,
    output logic [DATA_WIDTH-1:0] first_err_data,
    output logic                  sdram_req,
    input  logic                  sdram_ack,
    output logic [ADDR_WIDTH-1:0] sdram_addr,
    output logic                  sdram_rh_wl,
    output logic [DATA_WIDTH-1:0] sdram_data_w,
    input  logic [DATA_WIDTH-1:0] sdram_data_r,
    input  logic                  sdram_data_r_en
);

    localparam int CW = $clog2(TIMEOUT + WRITE_HOLD + 2);
    localparam logic [ADDR_WIDTH-1:0] LAST = ADDR_WIDTH'(NUM_WORDS - 1);
    localparam logic [CW-1:0] TO_LIM = CW'(TIMEOUT);
    localparam logic [CW-1:0] HOLD_LIM = CW'(WRITE_HOLD > 0 ? WRITE_HOLD - 1 : 0);

    typedef enum logic [2:0] {
        IDLE, WR_REQ, WR_HOLD, RD_REQ, RD_WAIT, PASS_END, DONE
    } state_t;

    state_t state, state_next;
    logic [CW-1:0] cnt, cnt_next;
    logic busy_next, done_next, timeout_next, req_next, rh_wl_next;
    logic [15:0] pass_next, err_next;
    logic [ADDR_WIDTH-1:0] addr_next, fea_next, addr_inc;
    logic [DATA_WIDTH-1:0] data_w_next, fed_next, expected;
    logic last, abort, counting;

    function automatic logic [DATA_WIDTH-1:0] pattern(
        input logic [ADDR_WIDTH-1:0] a,
        input logic [15:0]           p
    );
        logic [15:0] a16;
        a16 = 16'(a);
        return DATA_WIDTH'(a16 ^ {p[7:0], ~p[7:0]});
    endfunction

    always_comb begin
        state_next   = state;
        busy_next    = busy;
        done_next    = done;
        timeout_next = timeout;
        pass_next    = pass_cnt;
        err_next     = err_cnt;
        fea_next     = first_err_addr;
        fed_next     = first_err_data;
        addr_next    = sdram_addr;
        rh_wl_next   = sdram_rh_wl;
        data_w_next  = sdram_data_w;
        abort        = 1'b0;
        last         = (sdram_addr == LAST);
        addr_inc     = sdram_addr + ADDR_WIDTH'(1);
        expected     = pattern(sdram_addr, pass_cnt);

        unique case (state)
            IDLE, DONE: begin
                if (start) begin
                    pass_next    = '0;
                    err_next     = '0;
                    timeout_next = 1'b0;
                    fea_next     = '0;
                    fed_next     = '0;
                    addr_next    = '0;
                    rh_wl_next   = 1'b0;
                    data_w_next  = pattern('0, '0);
                    busy_next    = 1'b1;
                    done_next    = 1'b0;
                    state_next   = WR_REQ;
                end
            end
            WR_REQ: begin
                if (sdram_ack) state_next = WR_HOLD;
                else if (cnt == TO_LIM) abort = 1'b1;
            end
            WR_HOLD: begin
                if (cnt >= HOLD_LIM) begin
                    if (last) begin
                        addr_next  = '0;
                        rh_wl_next = 1'b1;
                        state_next = RD_REQ;
                    end else begin
                        addr_next   = addr_inc;
                        data_w_next = pattern(addr_inc, pass_cnt);
                        state_next  = WR_REQ;
                    end
                end
            end
            RD_REQ: begin
                if (sdram_ack) state_next = RD_WAIT;
                else if (cnt == TO_LIM) abort = 1'b1;
            end
            RD_WAIT: begin
                if (sdram_data_r_en) begin
                    if (sdram_data_r != expected) begin
                        if (err_cnt != 16'hFFFF) err_next = err_cnt + 16'd1;
                        if (err_cnt == 16'd0) begin
                            fea_next = sdram_addr;
                            fed_next = sdram_data_r;
                        end
                    end
                    if (last) begin
                        state_next = PASS_END;
                    end else begin
                        addr_next  = addr_inc;
                        state_next = RD_REQ;
                    end
                end else if (cnt == TO_LIM) begin
                    abort = 1'b1;
                end
            end
            PASS_END: begin
                pass_next = pass_cnt + 16'd1;
                if ((STOP_ON_ERR != 0 && err_cnt != 16'd0) || !loop) begin
                    busy_next  = 1'b0;
                    done_next  = 1'b1;
                    state_next = DONE;
                end else begin
                    addr_next   = '0;
                    rh_wl_next  = 1'b0;
                    data_w_next = pattern('0, pass_cnt + 16'd1);
                    state_next  = WR_REQ;
                end
            end
            default: state_next = IDLE;
        endcase

        if (abort) begin
            timeout_next = 1'b1;
            busy_next    = 1'b0;
            done_next    = 1'b1;
            state_next   = DONE;
        end

        // one watchdog/hold counter, restarted on every state entry
        counting = (state == WR_REQ) || (state == WR_HOLD) ||
                   (state == RD_REQ) || (state == RD_WAIT);
        if (counting && state_next == state) cnt_next = cnt + CW'(1);
        else cnt_next = '0;

        // req trails the request state by a cycle, but drops at once on abort
        req_next = ((state == WR_REQ) || (state == RD_REQ)) &&
                   (state_next != DONE);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state          <= IDLE;
            cnt            <= '0;
            busy           <= 1'b0;
            done           <= 1'b0;
            timeout        <= 1'b0;
            pass_cnt       <= '0;
            err_cnt        <= '0;
            first_err_addr <= '0;
            first_err_data <= '0;
            sdram_req      <= 1'b0;
            sdram_addr     <= '0;
            sdram_rh_wl    <= 1'b0;
            sdram_data_w   <= '0;
        end else begin
            state          <= state_next;
            cnt            <= cnt_next;
            busy           <= busy_next;
            done           <= done_next;
            timeout        <= timeout_next;
            pass_cnt       <= pass_next;
            err_cnt        <= err_next;
            first_err_addr <= fea_next;
            first_err_data <= fed_next;
            sdram_req      <= req_next;
            sdram_addr     <= addr_next;
            sdram_rh_wl    <= rh_wl_next;
            sdram_data_w   <= data_w_next;
        end
    end

endmodule

// File: tb/tb_sdram_test_seq.sv
// Bench for sdram_test_seq: behavioural SDRAM controller model,
// vector table, randomized runs, timeout and mid-read reset sequences.
module tb_sdram_test_seq;

    localparam int AW = 24;
    localparam int DW = 16;
    localparam int NW = 16;
    localparam int WH = 4;
    localparam int TO = 100;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic start = 1'b0;
    logic loop = 1'b0;
    logic busy, done, timeout;
    logic [15:0] pass_cnt, err_cnt;
    logic [AW-1:0] first_err_addr, sdram_addr;
    logic [DW-1:0] first_err_data, sdram_data_w, sdram_data_r;
    logic sdram_req, sdram_ack, sdram_rh_wl, sdram_data_r_en;

    int total = 0;
    int passed = 0;

    int ack_dly = 3;
    int dat_dly = 4;
    bit refresh = 1'b0;
    bit never_ack = 1'b0;
    int target = 1;
    int rd_count = 0;
    int acc = 0;
    logic [15:0] flip [64];
    logic [15:0] mem [16];
    logic [39:0] wlog [$];
    logic [23:0] rlog [$];

    typedef struct {
        int passes;
        int fp;
        int fa;
        logic [15:0] fm;
        bit refresh;
        int dly;
        int e_pass;
        int e_err;
        int e_fa;
        int e_fd;
    } vec_t;

    vec_t vecs [6];

    sdram_test_seq #(
        .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .NUM_WORDS(NW),
        .WRITE_HOLD(WH), .TIMEOUT(TO), .STOP_ON_ERR(1)
    ) dut (
        .clk(clk), .reset(rst), .start(start), .loop(loop),
        .busy(busy), .done(done), .timeout(timeout),
        .pass_cnt(pass_cnt), .err_cnt(err_cnt),
        .first_err_addr(first_err_addr), .first_err_data(first_err_data),
        .sdram_req(sdram_req), .sdram_ack(sdram_ack),
        .sdram_addr(sdram_addr), .sdram_rh_wl(sdram_rh_wl),
        .sdram_data_w(sdram_data_w), .sdram_data_r(sdram_data_r),
        .sdram_data_r_en(sdram_data_r_en)
    );

    initial forever #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] act,
                         input logic [63:0] req);
        total++;
        if (act === req) passed++;
        else $display("FAIL %s: got %0h, want %0h", name, act, req);
    endtask

    function automatic logic [15:0] ref_pat(input int a, input int p);
        int pl;
        pl = p % 256;
        return 16'(a % 65536) ^ 16'(pl * 256 + (255 - pl));
    endfunction

    // Loop is held high until the wanted number of passes is reached.
    initial forever begin
        @(negedge clk);
        loop = (int'(pass_cnt) + 1 < target);
    end

    // Controller model: ack after a delay, read data later, checks stability.
    initial begin : model
        int ph;
        int cm;
        logic [23:0] l_addr;
        logic l_rw;
        logic [15:0] l_data;
        ph = 0;
        cm = 0;
        l_addr = '0;
        l_rw = 1'b0;
        l_data = '0;
        sdram_ack = 1'b0;
        sdram_data_r_en = 1'b0;
        sdram_data_r = '0;
        forever begin
            @(negedge clk);
            sdram_ack = 1'b0;
            sdram_data_r_en = 1'b0;
            if (rst) begin
                ph = 0;
            end else begin
                if (ph != 0) begin
                    check("stab_addr", sdram_addr, l_addr);
                    check("stab_rh_wl", sdram_rh_wl, l_rw);
                    if (!l_rw) check("stab_data_w", sdram_data_w, l_data);
                end
                case (ph)
                    0: if (sdram_req && !never_ack) begin
                        l_addr = sdram_addr;
                        l_rw = sdram_rh_wl;
                        l_data = sdram_data_w;
                        cm = ack_dly + ((refresh && acc % 4 == 3) ? 20 : 0);
                        acc++;
                        ph = 1;
                    end
                    1: if (cm > 1) cm--;
                    else begin
                        sdram_ack = 1'b1;
                        if (l_rw) begin
                            rlog.push_back(l_addr);
                            cm = dat_dly;
                            ph = 2;
                        end else begin
                            mem[l_addr[3:0]] = l_data;
                            wlog.push_back({l_addr, l_data});
                            cm = WH;
                            ph = 3;
                        end
                    end
                    2: if (cm > 1) cm--;
                    else begin
                        sdram_data_r = mem[l_addr[3:0]] ^
                                       (rd_count < 64 ? flip[rd_count] : 16'h0);
                        sdram_data_r_en = 1'b1;
                        rd_count++;
                        ph = 0;
                    end
                    3: if (cm > 1) cm--;
                    else ph = 0;
                    default: ph = 0;
                endcase
            end
        end
    end

    task automatic ref_run(input int passes, output int e_pass,
                           output int e_err, output int e_fa, output int e_fd);
        e_pass = 0;
        e_err = 0;
        e_fa = 0;
        e_fd = 0;
        for (int p = 0; p < passes; p++) begin
            for (int a = 0; a < NW; a++) begin
                if (flip[p * NW + a] != 16'h0) begin
                    if (e_err == 0) begin
                        e_fa = a;
                        e_fd = int'(ref_pat(a, p) ^ flip[p * NW + a]);
                    end
                    e_err++;
                end
            end
            e_pass++;
            if (e_err > 0) break;
        end
    endtask

    task automatic run(input int passes);
        int cyc;
        wlog.delete();
        rlog.delete();
        rd_count = 0;
        acc = 0;
        target = passes;
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        cyc = 0;
        while (!done && cyc < 20000) begin
            @(negedge clk);
            cyc++;
        end
    endtask

    task automatic check_result(input string tag, input int e_pass,
                                input int e_err, input int e_fa, input int e_fd);
        int bad;
        check({tag, "_done"}, done, 1);
        check({tag, "_busy"}, busy, 0);
        check({tag, "_req"}, sdram_req, 0);
        check({tag, "_timeout"}, timeout, 0);
        check({tag, "_pass_cnt"}, pass_cnt, e_pass);
        check({tag, "_err_cnt"}, err_cnt, e_err);
        check({tag, "_first_addr"}, first_err_addr, e_fa);
        check({tag, "_first_data"}, first_err_data, e_fd);
        check({tag, "_n_writes"}, wlog.size(), e_pass * NW);
        check({tag, "_n_reads"}, rlog.size(), e_pass * NW);
        bad = 0;
        foreach (wlog[k])
            if (wlog[k] !== {24'(k % NW), ref_pat(k % NW, k / NW)}) bad++;
        foreach (rlog[k])
            if (rlog[k] !== 24'(k % NW)) bad++;
        check({tag, "_seq_bad"}, bad, 0);
    endtask

    task automatic check_reset(input string tag);
        check({tag, "_busy"}, busy, 0);
        check({tag, "_done"}, done, 0);
        check({tag, "_timeout"}, timeout, 0);
        check({tag, "_req"}, sdram_req, 0);
        check({tag, "_rh_wl"}, sdram_rh_wl, 0);
        check({tag, "_addr"}, sdram_addr, 0);
        check({tag, "_data_w"}, sdram_data_w, 0);
        check({tag, "_pass_cnt"}, pass_cnt, 0);
        check({tag, "_err_cnt"}, err_cnt, 0);
        check({tag, "_first_addr"}, first_err_addr, 0);
        check({tag, "_first_data"}, first_err_data, 0);
    endtask

    initial begin
        int e_pass, e_err, e_fa, e_fd, cyc, k;
        vecs[0] = '{1, 0, 0, 16'h0000, 1'b0, 3, 1, 0, 0, 0};
        vecs[1] = '{1, 0, 5, 16'h0008, 1'b0, 3, 1, 1, 5, 16'h00F2};
        vecs[2] = '{3, 0, 0, 16'h0000, 1'b0, 3, 3, 0, 0, 0};
        vecs[3] = '{2, 0, 0, 16'h0000, 1'b1, 3, 2, 0, 0, 0};
        vecs[4] = '{3, 1, 9, 16'h8000, 1'b0, 3, 2, 1, 9, 16'h81F7};
        vecs[5] = '{3, 0, 15, 16'h0001, 1'b1, 2, 1, 1, 15, 16'h00F1};
        foreach (flip[i]) flip[i] = 16'h0;
        foreach (mem[i]) mem[i] = 16'h0;

        #1;
        check_reset("reset");
        repeat (3) @(negedge clk);
        rst = 1'b0;

        foreach (vecs[i]) begin
            foreach (flip[j]) flip[j] = 16'h0;
            flip[vecs[i].fp * NW + vecs[i].fa] = vecs[i].fm;
            refresh = vecs[i].refresh;
            ack_dly = vecs[i].dly;
            dat_dly = 4;
            run(vecs[i].passes);
            check_result($sformatf("vec%0d", i), vecs[i].e_pass,
                         vecs[i].e_err, vecs[i].e_fa, vecs[i].e_fd);
            if (vecs[i].passes == 3 && wlog.size() > 33)
                check("wr_p2_a1", wlog[33][15:0], 16'h02FC);
        end

        for (int r = 0; r < 6; r++) begin
            int passes;
            passes = int'($urandom_range(1, 3));
            ack_dly = int'($urandom_range(1, 6));
            dat_dly = int'($urandom_range(1, 5));
            refresh = 1'($urandom_range(0, 1));
            foreach (flip[j]) flip[j] = 16'h0;
            if ($urandom_range(0, 1) == 1) begin
                k = int'($urandom_range(0, 3));
                for (int j = 0; j <= k; j++)
                    flip[$urandom_range(0, passes * NW - 1)] =
                        16'($urandom_range(1, 65535));
            end
            ref_run(passes, e_pass, e_err, e_fa, e_fd);
            run(passes);
            check_result($sformatf("rnd%0d", r), e_pass, e_err, e_fa, e_fd);
        end

        foreach (flip[j]) flip[j] = 16'h0;
        refresh = 1'b0;
        ack_dly = 3;
        dat_dly = 4;
        never_ack = 1'b1;
        target = 1;
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        cyc = 0;
        while (!sdram_req && cyc < 10) begin
            @(negedge clk);
            cyc++;
        end
        check("wd_req_rise", sdram_req, 1);
        k = 0;
        while (!done && k < TO + 50) begin
            @(negedge clk);
            k++;
        end
        check("wd_latency", k, TO);
        check("wd_timeout", timeout, 1);
        check("wd_done", done, 1);
        check("wd_busy", busy, 0);
        check("wd_req", sdram_req, 0);
        check("wd_pass_cnt", pass_cnt, 0);
        never_ack = 1'b0;

        target = 1;
        wlog.delete();
        rlog.delete();
        rd_count = 0;
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        cyc = 0;
        while (!(sdram_req && sdram_rh_wl && sdram_addr == 24'd7) &&
               cyc < 5000) begin
            @(negedge clk);
            cyc++;
        end
        check("mid_rd_addr", sdram_addr, 7);
        rst = 1'b1;
        #1;
        check_reset("mid_rst");
        repeat (2) @(negedge clk);
        rst = 1'b0;
        run(1);
        check_result("after_rst", 1, 0, 0, 0);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
